// File: rtl/mul_pipe_ctrl.sv
// Two-stage 32x32 multiply pipeline with valid/ready handshakes, flush and async reset.
// S1 holds the operands, S2 holds the 64-bit product, and out_result selects one half of it.

module team_mul (
  input  logic        mul_clk,
  input  logic        reset,
  input  logic        mul_signed,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [63:0] result
);
  logic signed [32:0] x_ext;
  logic signed [32:0] y_ext;
  logic signed [65:0] prod;
  logic               unused_ctrl;

  // A 33-bit extension lets one signed multiplier serve both signed and unsigned operands.
  assign x_ext  = {mul_signed & x[31], x};
  assign y_ext  = {mul_signed & y[31], y};
  assign prod   = x_ext * y_ext;
  assign result = prod[63:0];

  assign unused_ctrl = &{1'b0, mul_clk, reset, prod[65:64]};
endmodule

module mul_pipe_ctrl (
  input  logic        mul_clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  mul_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result
);
  logic               s1_valid;
  logic               s2_valid;
  logic [31:0]        src1_p1;
  logic [31:0]        src2_p1;
  logic [1:0]         op_p1;
  logic [63:0]        prod_p2;
  logic [1:0]         op_p2;
  logic [63:0]        mul_result;
  logic               mul_signed;
  logic               s2_load;
  logic               s1_load;
  logic               accept;

  function automatic logic [31:0] sel_half(input logic [1:0] op, input logic [63:0] p);
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load && !flush && !reset;
  assign accept   = in_valid && in_ready;

  assign mul_signed = ~op_p1[1];

  team_mul u_mul (
    .mul_clk    (mul_clk),
    .reset      (reset),
    .mul_signed (mul_signed),
    .x          (src1_p1),
    .y          (src2_p1),
    .result     (mul_result)
  );

  // Flush drops both stages; data registers are left untouched since only the valids carry state.
  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      src1_p1  <= '0;
      src2_p1  <= '0;
      op_p1    <= '0;
      prod_p2  <= '0;
      op_p2    <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      // S1 -> S2 boundary
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          prod_p2 <= mul_result;
          op_p2   <= op_p1;
        end
      end
      // input -> S1 boundary
      if (s1_load) begin
        s1_valid <= accept;
        if (accept) begin
          src1_p1 <= src1;
          src2_p1 <= src2;
          op_p1   <= mul_op;
        end
      end
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = sel_half(op_p2, prod_p2);
endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// Directed bench for mul_pipe_ctrl: reset, signed/unsigned halves, streaming,
// backpressure, flush and asynchronous mid-flight reset.

module tb_mul_pipe_ctrl;
  logic        mul_clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mul_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  int checks;
  int errors;

  mul_pipe_ctrl dut (
    .mul_clk    (mul_clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mul_op     (mul_op),
    .src1       (src1),
    .src2       (src2),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  initial begin
    mul_clk = 1'b0;
    forever #5 mul_clk = ~mul_clk;
  end

  task automatic step();
    @(posedge mul_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    step();
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_result !== 32'h0) begin errors++; $display("FAIL post_rst_result: got %h expected 00000000", out_result); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid: got %b expected 0", out_valid); end
    step();
  endtask

  // One isolated request; result must show in the second cycle after it is presented, for exactly one cycle.
  task automatic test_signed();
    logic [1:0]  ops [7];
    logic [31:0] opa [7];
    logic [31:0] exp [7];
    ops = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
    opa = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'h80000000, 32'h80000000, 32'h80000000};
    exp = '{32'h00000001, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFE,
            32'h40000000, 32'h00000000, 32'h40000000};
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      mul_op   = ops[k];
      src1     = opa[k];
      src2     = opa[k];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready[%0d]: got %b expected 1", k, in_ready); end
      step();
      in_valid = 1'b0;
      src1     = 32'h12345678;
      src2     = 32'h9ABCDEF0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early[%0d]: got out_valid %b expected 0", k, out_valid); end
      step();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b expected 1", k, out_valid); end
      checks++;
      if (out_result !== exp[k]) begin errors++; $display("FAIL single_result[%0d]: got %h expected %h", k, out_result, exp[k]); end
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain[%0d]: got out_valid %b expected 0", k, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [8];
    exp = '{32'd0, 32'd24, 32'd54, 32'd90, 32'd132, 32'd180, 32'd234, 32'd294};
    out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        in_valid = 1'b1;
        mul_op   = 2'b00;
        src1     = 32'(c * 3);
        src2     = 32'(c + 7);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", c, in_ready); end
      end else begin
        in_valid = 1'b0;
        #1;
      end
      if (c >= 2 && c < 10) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== exp[c-2])
          begin errors++; $display("FAIL stream_out[%0d]: got v=%b %h expected v=1 %h", c - 2, out_valid, out_result, exp[c-2]); end
      end else begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_idle[%0d]: got out_valid %b expected 0", c, out_valid); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    mul_op    = 2'b00;
    in_valid  = 1'b1; src1 = 32'd2; src2 = 32'd3;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_a: got in_ready %b expected 1", in_ready); end
    step();
    src1 = 32'd5; src2 = 32'd7;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_b: got in_ready %b expected 1", in_ready); end
    step();
    src1 = 32'd11; src2 = 32'd13;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0", c, in_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'd6)
        begin errors++; $display("FAIL bp_hold[%0d]: got v=%b %h expected v=1 00000006", c, out_valid, out_result); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd6)
      begin errors++; $display("FAIL bp_out_a: got v=%b %h expected v=1 00000006", out_valid, out_result); end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd35)
      begin errors++; $display("FAIL bp_out_b: got v=%b %h expected v=1 00000023", out_valid, out_result); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd143)
      begin errors++; $display("FAIL bp_out_c: got v=%b %h expected v=1 0000008f", out_valid, out_result); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    mul_op    = 2'b00;
    in_valid  = 1'b1; src1 = 32'd3; src2 = 32'd4;
    step();
    src1 = 32'd4; src2 = 32'd5;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd12)
      begin errors++; $display("FAIL flush_prefill: got v=%b %h expected v=1 0000000c", out_valid, out_result); end
    flush = 1'b1; out_ready = 1'b1; src1 = 32'd100; src2 = 32'd100;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear1: got out_valid %b expected 0", out_valid); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear2: got out_valid %b expected 0", out_valid); end
    in_valid = 1'b1; src1 = 32'd7; src2 = 32'd6;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after_early: got out_valid %b expected 0", out_valid); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd42)
      begin errors++; $display("FAIL flush_after_result: got v=%b %h expected v=1 0000002a", out_valid, out_result); end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    mul_op    = 2'b01;
    in_valid  = 1'b1; src1 = 32'h80000000; src2 = 32'h80000000;
    step();
    src1 = 32'hFFFFFFFF; src2 = 32'hFFFFFFFF;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h40000000)
      begin errors++; $display("FAIL areset_prefill: got v=%b %h expected v=1 40000000", out_valid, out_result); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_immediate: got out_valid %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_in_ready: got %b expected 0", in_ready); end
    step();
    #2;
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b0 || out_result !== 32'h0)
        begin errors++; $display("FAIL areset_stale[%0d]: got v=%b %h expected v=0 00000000", c, out_valid, out_result); end
      step();
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    mul_op    = 2'b00;
    src1      = 32'h0;
    src2      = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
